// File: rtl/act_stage.sv
// act_stage: post-accumulation stage downstream of the MAC.
//
// A MAC done pulse captures mac_out + bias as a 17-bit signed sum (S1).
// In the next cycle (S2) the sum is saturated to signed Q8.8, passed through
// the activation and pushed into a small FIFO. The FIFO head is presented to
// the next layer over a valid/ready handshake.
//
// Configuration macro: ACT_RELU_EN
//   defined   -> ReLU after saturation (negative results become 0x0000)
//   undefined -> identity activation
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   CW     width of count, clog2(DEPTH+1)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset, clears all state
//   done_in    in   MAC done pulse, mac_out/bias sampled in this cycle
//   mac_out    in   [15:0] signed Q8.8 accumulated sum
//   bias       in   [15:0] signed Q8.8 bias
//   out_data   out  [15:0] result at FIFO head (don't-care when !out_valid)
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer accepts the head
//   count      out  [CW-1:0] FIFO occupancy, 0..DEPTH
//   overflow   out  sticky: a result was dropped on a full FIFO
//
// Handshake: a transfer happens on every rising edge where out_valid and
// out_ready are both 1. out_valid depends only on FIFO occupancy, never on
// out_ready; out_data is stable while out_valid=1 and no transfer occurs.
// out_ready while out_valid=0 is ignored.

module act_stage #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          done_in,
  input  logic [15:0]   mac_out,
  input  logic [15:0]   bias,
  output logic [15:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // S1 capture register
  logic [16:0] s1_sum;
  logic        s1_v;

  // FIFO storage and pointers
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // S2 combinational path
  logic [15:0] sat_val;
  logic [15:0] act_val;
  logic        pop;
  logic        push_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_sum <= '0;
      s1_v   <= 1'b0;
    end else begin
      s1_v <= done_in;
      if (done_in) begin
        s1_sum <= {mac_out[15], mac_out} + {bias[15], bias};
      end
    end
  end

  // The 17-bit sum fits in 16 bits exactly when bits 16 and 15 agree;
  // otherwise bit 16 carries the true sign and selects the clamp direction.
  always_comb begin
    sat_val = s1_sum[15:0];
    if (!s1_sum[16] && s1_sum[15]) begin
      sat_val = 16'h7FFF;
    end else if (s1_sum[16] && !s1_sum[15]) begin
      sat_val = 16'h8000;
    end
  end

`ifdef ACT_RELU_EN
  assign act_val = sat_val[15] ? 16'h0000 : sat_val;
`else
  assign act_val = sat_val;
`endif

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  // A full FIFO still takes the new result when the head leaves this cycle.
  assign push_ok   = s1_v & ((count != FULL_CNT) | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= act_val;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s1_v && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_act_stage.sv
module tb_act_stage;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk;
  logic          reset;
  logic          done_in;
  logic [15:0]   mac_out;
  logic [15:0]   bias;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow;

  int total;
  int bad;

  act_stage #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .done_in   (done_in),
    .mac_out   (mac_out),
    .bias      (bias),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Scoreboard queue of results the FIFO should hold, oldest first.
  logic [15:0] exp_q[$];
  logic        m_s1_v;
  logic [15:0] m_s1_val;
  logic        m_ovf;

  function automatic logic [15:0] act_model(input logic [15:0] m, input logic [15:0] b);
    int sm;
    int sb;
    int s;
    sm = $signed(m);
    sb = $signed(b);
    s  = sm + sb;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`ifdef ACT_RELU_EN
    if (s < 0) s = 0;
`endif
    return 16'(s);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_s1_v   = 1'b0;
    m_s1_val = '0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_step(input logic d, input logic [15:0] m, input logic [15:0] b,
                            input logic r);
    if (exp_q.size() > 0 && r) void'(exp_q.pop_front());
    if (m_s1_v) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(m_s1_val);
      else m_ovf = 1'b1;
    end
    m_s1_v   = d;
    m_s1_val = act_model(m, b);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("count", 32'(count), exp_q.size());
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (exp_q.size() > 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drives inputs for one cycle, advances the model at
  // the rising edge and checks outputs at the following negedge.
  task automatic cycle(input logic d, input logic [15:0] m, input logic [15:0] b,
                       input logic r);
    done_in   = d;
    mac_out   = m;
    bias      = b;
    out_ready = r;
    @(posedge clk);
    model_step(d, m, b, r);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    done_in = 1'b0; out_ready = 1'b0; mac_out = '0; bias = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [15:0] mac;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    done_in = 1'b0; out_ready = 1'b0; mac_out = '0; bias = '0;
    model_reset();

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_data", 32'(out_data), 0);
    reset = 1'b0;

    // ---- table-driven single results ----
`ifdef ACT_RELU_EN
    tbl[0] = '{16'h0180, 16'h0080, 16'h0200};
    tbl[1] = '{16'h7F00, 16'h0200, 16'h7FFF};
    tbl[2] = '{16'h8100, 16'hFE00, 16'h0000};
    tbl[3] = '{16'hFF00, 16'h0000, 16'h0000};
    tbl[4] = '{16'h0100, 16'hFF00, 16'h0000};
    tbl[5] = '{16'h8000, 16'h8000, 16'h0000};
    tbl[6] = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    tbl[7] = '{16'h1234, 16'hF000, 16'h0234};
`else
    tbl[0] = '{16'h0180, 16'h0080, 16'h0200};
    tbl[1] = '{16'h7F00, 16'h0200, 16'h7FFF};
    tbl[2] = '{16'h8100, 16'hFE00, 16'h8000};
    tbl[3] = '{16'hFF00, 16'h0000, 16'hFF00};
    tbl[4] = '{16'h0100, 16'hFF00, 16'h0000};
    tbl[5] = '{16'h8000, 16'h8000, 16'h8000};
    tbl[6] = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    tbl[7] = '{16'h1234, 16'hF000, 16'h0234};
`endif
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].mac, tbl[i].b, 1'b0);
      chk("tbl_lat_valid", 32'(out_valid), 0);
      cycle(1'b0, 16'h0, 16'h0, 1'b0);
      chk("tbl_valid", 32'(out_valid), 1);
      chk("tbl_count", 32'(count), 1);
      chk("tbl_data", 32'(out_data), 32'(tbl[i].exp));
      cycle(1'b0, 16'h0, 16'h0, 1'b1);
      chk("tbl_pop_count", 32'(count), 0);
      chk("tbl_pop_valid", 32'(out_valid), 0);
    end

    // ---- fill and overflow ----
    do_reset();
    for (int k = 1; k <= 5; k++) cycle(1'b1, 16'(k), 16'h0, 1'b0);
    repeat (2) cycle(1'b0, 16'h0, 16'h0, 1'b0);
    chk("fill_count", 32'(count), 4);
    chk("fill_overflow", 32'(overflow), 1);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_data", 32'(out_data), k);
      cycle(1'b0, 16'h0, 16'h0, 1'b1);
    end
    chk("drain_count", 32'(count), 0);
    chk("drain_overflow", 32'(overflow), 1);

    // ---- async reset mid-operation (count=3, s1_v=1, overflow=1) ----
    for (int k = 1; k <= 4; k++) cycle(1'b1, 16'(16 + k), 16'h0, 1'b0);
    chk("pre_rst_count", 32'(count), 3);
    done_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_overflow", 32'(overflow), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cycle(1'b0, 16'h0, 16'h0, 1'b0);
    chk("post_rst_valid", 32'(out_valid), 0);

    // ---- full with simultaneous pop ----
    do_reset();
    for (int k = 1; k <= 5; k++) cycle(1'b1, 16'(k), 16'h0, 1'b0);
    cycle(1'b0, 16'h0, 16'h0, 1'b1);  // write cycle of the 5th result
    chk("fullpop_count", 32'(count), 4);
    chk("fullpop_overflow", 32'(overflow), 0);
    for (int k = 2; k <= 5; k++) begin
      chk("fullpop_data", 32'(out_data), k);
      cycle(1'b0, 16'h0, 16'h0, 1'b1);
    end
    chk("fullpop_empty", 32'(count), 0);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int ready_pct;
      ready_pct = (n < 200) ? 70 : 30;
      cycle($urandom_range(0, 99) < 60,
            16'($urandom_range(0, 65535)),
            16'($urandom_range(0, 65535)),
            $urandom_range(0, 99) < ready_pct);
    end
    repeat (DEPTH + 2) cycle(1'b0, 16'h0, 16'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
